// File: rtl/io_write_sequencer_if.sv
// ============================================================================
// io_write_sequencer_if : core I/O bus plus peripheral drain handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface io_write_sequencer_if;
    logic        IOWriteEn;
    logic [3:0]  IOAddr;
    logic [31:0] IOWriteData;
    logic [31:0] IOReadData;
    logic [31:0] ExtIn;
    logic        PerValid;
    logic [3:0]  PerAddr;
    logic [31:0] PerData;
    logic        PerReady;
    logic        Full;
    logic        Empty;
    logic        Overflow;

    modport master (
        output IOWriteEn, IOAddr, IOWriteData, ExtIn, PerReady,
        input  IOReadData, PerValid, PerAddr, PerData, Full, Empty, Overflow
    );

    modport slave (
        input  IOWriteEn, IOAddr, IOWriteData, ExtIn, PerReady,
        output IOReadData, PerValid, PerAddr, PerData, Full, Empty, Overflow
    );
endinterface

`default_nettype wire

// File: rtl/io_write_sequencer.sv
// ============================================================================
// io_write_sequencer : queues core I/O writes and drains them to a peripheral
// Rev 1.0
// ============================================================================
`default_nettype none

module io_write_sequencer #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  wire logic             CLK,
    input  wire logic             RESET_N,
    io_write_sequencer_if.slave   bus
);
    localparam int            c_PW             = LW - 1;
    localparam int            c_NSHADOW        = 14;
    localparam logic [3:0]    c_ADDR_LAST_DATA = 4'hD;
    localparam logic [3:0]    c_ADDR_STATUS    = 4'hE;
    localparam logic [3:0]    c_ADDR_EXT       = 4'hF;
    localparam logic [LW-1:0] c_DEPTH_CNT      = LW'(DEPTH);

    logic [35:0]     mem_q [DEPTH];
    logic [c_PW-1:0] wptr_q, wptr_d;
    logic [c_PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [31:0]     shadow_q [c_NSHADOW];
    logic            ovf_q, ovf_d;
    logic [31:0]     sync1_q, sync2_q;

    logic        w_full, w_empty;
    logic        w_data_wr, w_status_wr;
    logic        w_pop, w_push, w_drop;
    logic [35:0] w_head;
    logic [31:0] w_rdata;

    assign w_full  = (count_q == c_DEPTH_CNT);
    assign w_empty = (count_q == '0);
    assign w_head  = mem_q[rptr_q];

    always_comb begin
        w_data_wr   = bus.IOWriteEn && (bus.IOAddr <= c_ADDR_LAST_DATA);
        w_status_wr = bus.IOWriteEn && (bus.IOAddr == c_ADDR_STATUS);
        w_pop       = !w_empty && bus.PerReady;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        w_push      = w_data_wr && (!w_full || w_pop);
        w_drop      = w_data_wr && w_full && !w_pop;

        wptr_d  = w_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = w_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Setting wins over a same-cycle status clear.
        if (w_drop)
            ovf_d = 1'b1;
        else if (w_status_wr)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < c_NSHADOW; i++)
                shadow_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sync1_q <= bus.ExtIn;
            sync2_q <= sync1_q;
            for (int i = 0; i < c_NSHADOW; i++)
                if (w_push && (bus.IOAddr == 4'(i)))
                    shadow_q[i] <= bus.IOWriteData;
        end
    end

    // Storage is left uninitialised; the pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (RESET_N && w_push)
            mem_q[wptr_q] <= {bus.IOAddr, bus.IOWriteData};
    end

    always_comb begin
        w_rdata = '0;
        if (bus.IOAddr == c_ADDR_STATUS)
            w_rdata = {24'b0, 5'(count_q), ovf_q, w_full, w_empty};
        else if (bus.IOAddr == c_ADDR_EXT)
            w_rdata = sync2_q;
        else
            for (int i = 0; i < c_NSHADOW; i++)
                if (bus.IOAddr == 4'(i))
                    w_rdata = shadow_q[i];
    end

    assign bus.IOReadData = w_rdata;
    assign bus.PerValid   = !w_empty;
    assign bus.PerAddr    = w_empty ? 4'h0  : w_head[35:32];
    assign bus.PerData    = w_empty ? 32'h0 : w_head[31:0];
    assign bus.Full       = w_full;
    assign bus.Empty      = w_empty;
    assign bus.Overflow   = ovf_q;

endmodule

`default_nettype wire
